// File: rtl/sel_pipe.sv
// Configurable-depth delay line with shared clock enable, per-stage valid,
// synchronous flush and a saturating fill counter; DEPTH=0 degenerates to a wire.
module sel_pipe #(
  parameter int unsigned      WIDTH    = 18,
  parameter int unsigned      DEPTH    = 2,
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  parameter bit               VLD_GATE = 1'b0,
  localparam int unsigned     FILL_W   = (DEPTH == 0) ? 1 : $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              flush,
  input  logic [WIDTH-1:0]  d,
  input  logic              d_vld,
  output logic [WIDTH-1:0]  q,
  output logic              q_vld,
  output logic [FILL_W-1:0] fill,
  output logic              primed
);

  if (DEPTH == 0) begin : g_bypass
    assign q      = d;
    assign q_vld  = d_vld;
    assign fill   = '0;
    assign primed = 1'b1;

    // Control inputs are meaningless without storage.
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, ce, flush};
  end else begin : g_pipe
    logic [WIDTH-1:0]  s_q [DEPTH];
    logic [DEPTH-1:0]  v_q;
    logic [FILL_W-1:0] fill_q;

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        for (int k = 0; k < DEPTH; k++) begin
          s_q[k] <= RST_VAL;
        end
        v_q    <= '0;
        fill_q <= '0;
      end else if (ce) begin
        // With gating, a stage keeps its last valid word across bubbles.
        if (!VLD_GATE || d_vld) begin
          s_q[0] <= d;
        end
        v_q[0] <= d_vld;
        for (int k = 1; k < DEPTH; k++) begin
          if (!VLD_GATE || v_q[k-1]) begin
            s_q[k] <= s_q[k-1];
          end
          v_q[k] <= v_q[k-1];
        end
        if (fill_q != FILL_W'(DEPTH)) begin
          fill_q <= fill_q + FILL_W'(1);
        end
      end
    end

    assign q      = s_q[DEPTH-1];
    assign q_vld  = v_q[DEPTH-1];
    assign fill   = fill_q;
    assign primed = (fill_q == FILL_W'(DEPTH));
  end

endmodule

// File: tb/tb_sel_pipe.sv
// Directed plus random checks of several sel_pipe configurations against a
// history-of-shifts model sharing one stimulus stream.
module tb_sel_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, ce, d_vld;
  logic [17:0] d;

  logic [17:0] q3, q2, qg2, q4, q5, q0;
  logic        v3, v2, vg2, v4, v5, v0;
  logic [1:0]  f3, f2, fg2;
  logic [2:0]  f4, f5;
  logic [0:0]  f0;
  logic        p3, p2, pg2, p4, p5, p0;

  int total = 0;
  int fails = 0;

  // Words shifted in since the last clear, oldest first.
  logic [17:0] hd[$];
  bit          hv[$];

  always #5 clk = ~clk;

  sel_pipe #(.WIDTH(18), .DEPTH(3), .RST_VAL(18'h155), .VLD_GATE(1'b0)) u_d3 (
    .clk(clk), .rst(rst), .ce(ce), .flush(flush), .d(d), .d_vld(d_vld),
    .q(q3), .q_vld(v3), .fill(f3), .primed(p3));
  sel_pipe #(.WIDTH(18), .DEPTH(2), .RST_VAL(18'h0), .VLD_GATE(1'b0)) u_d2 (
    .clk(clk), .rst(rst), .ce(ce), .flush(flush), .d(d), .d_vld(d_vld),
    .q(q2), .q_vld(v2), .fill(f2), .primed(p2));
  sel_pipe #(.WIDTH(18), .DEPTH(2), .RST_VAL(18'h0), .VLD_GATE(1'b1)) u_g2 (
    .clk(clk), .rst(rst), .ce(ce), .flush(flush), .d(d), .d_vld(d_vld),
    .q(qg2), .q_vld(vg2), .fill(fg2), .primed(pg2));
  sel_pipe #(.WIDTH(18), .DEPTH(4), .RST_VAL(18'h05A), .VLD_GATE(1'b0)) u_d4 (
    .clk(clk), .rst(rst), .ce(ce), .flush(flush), .d(d), .d_vld(d_vld),
    .q(q4), .q_vld(v4), .fill(f4), .primed(p4));
  sel_pipe #(.WIDTH(18), .DEPTH(5), .RST_VAL(18'h2AA), .VLD_GATE(1'b1)) u_d5 (
    .clk(clk), .rst(rst), .ce(ce), .flush(flush), .d(d), .d_vld(d_vld),
    .q(q5), .q_vld(v5), .fill(f5), .primed(p5));
  sel_pipe #(.WIDTH(18), .DEPTH(0), .RST_VAL(18'h0), .VLD_GATE(1'b0)) u_d0 (
    .clk(clk), .rst(rst), .ce(ce), .flush(flush), .d(d), .d_vld(d_vld),
    .q(q0), .q_vld(v0), .fill(f0), .primed(p0));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // The last stage holds the word shifted in DEPTH shifts ago; with gating it
  // holds the newest valid word at least that old.
  task automatic check_pipe(input string nm, input int depth, input bit gate,
                            input logic [17:0] rv, input logic [17:0] oq, input logic ov,
                            input int of, input logic op);
    int          n;
    int          idx;
    logic [17:0] eq;
    logic        ev;
    int          ef;
    n  = hd.size();
    ef = (n < depth) ? n : depth;
    eq = rv;
    ev = 1'b0;
    if (n >= depth) begin
      idx = n - depth;
      ev  = hv[idx];
      if (!gate) begin
        eq = hd[idx];
      end else begin
        for (int j = idx; j >= 0; j--) begin
          if (hv[j]) begin
            eq = hd[j];
            break;
          end
        end
      end
    end
    check({nm, "_q"}, 64'(oq), 64'(eq));
    check({nm, "_vld"}, 64'(ov), 64'(ev));
    check({nm, "_fill"}, 64'(of), 64'(ef));
    check({nm, "_primed"}, 64'(op), 64'(ef == depth));
  endtask

  task automatic step(input bit r, input bit f, input bit c, input logic [17:0] dd,
                      input bit dv);
    rst   = r;
    flush = f;
    ce    = c;
    d     = dd;
    d_vld = dv;
    #1;
    check("d0_q", 64'(q0), 64'(dd));
    check("d0_vld", 64'(v0), 64'(dv));
    check("d0_fill", 64'(f0), 64'd0);
    check("d0_primed", 64'(p0), 64'd1);
    @(posedge clk);
    if (r || f) begin
      hd.delete();
      hv.delete();
    end else if (c) begin
      hd.push_back(dd);
      hv.push_back(dv);
    end
    #1;
    check_pipe("d3", 3, 1'b0, 18'h155, q3, v3, int'(f3), p3);
    check_pipe("d2", 2, 1'b0, 18'h000, q2, v2, int'(f2), p2);
    check_pipe("g2", 2, 1'b1, 18'h000, qg2, vg2, int'(fg2), pg2);
    check_pipe("d4", 4, 1'b0, 18'h05A, q4, v4, int'(f4), p4);
    check_pipe("d5", 5, 1'b1, 18'h2AA, q5, v5, int'(f5), p5);
  endtask

  initial begin
    // Reset with ce high and live data: data must be discarded.
    step(1, 0, 1, 18'h3FFFF, 1);
    step(1, 0, 1, 18'h3FFFF, 1);
    check("d3_rst_q", 64'(q3), 64'h155);
    check("d3_rst_fill", 64'(f3), 64'd0);
    step(0, 0, 1, 18'h3FFFF, 1);
    step(0, 0, 1, 18'h3FFFF, 1);
    check("d3_pre_primed", 64'(p3), 64'd0);
    step(0, 0, 1, 18'h3FFFF, 1);
    check("d3_third_q", 64'(q3), 64'h3FFFF);
    check("d3_third_primed", 64'(p3), 64'd1);

    // Latency with a ce stall mid-stream.
    step(1, 0, 0, 18'h0, 0);
    step(0, 0, 1, 18'd1, 1);
    step(0, 0, 1, 18'd2, 1);
    check("d2_lat_q", 64'(q2), 64'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 18'h2BAD, 0);
    check("d2_stall_fill", 64'(f2), 64'd2);
    step(0, 0, 1, 18'd3, 1);
    check("d2_resume_q", 64'(q2), 64'd2);
    step(0, 0, 1, 18'd4, 1);
    step(0, 0, 1, 18'd0, 0);
    step(0, 0, 1, 18'd0, 0);

    // Flush with ce and fresh data on the same edge.
    step(1, 0, 0, 18'h0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 18'hA0 + 18'(i), 1);
    check("d4_full_q", 64'(q4), 64'hA0);
    step(0, 1, 1, 18'hBB, 1);
    check("d4_flush_q", 64'(q4), 64'h05A);
    check("d4_flush_fill", 64'(f4), 64'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 18'h0, 0);
    check("d4_no_bb", 64'(q4), 64'h0);

    // Valid gating versus plain shifting.
    step(1, 0, 0, 18'h0, 0);
    step(0, 0, 1, 18'h11, 1);
    step(0, 0, 1, 18'h22, 0);
    check("g2_first", 64'(qg2), 64'h11);
    step(0, 0, 1, 18'h33, 1);
    check("g2_hold", 64'(qg2), 64'h11);
    check("d2_mid", 64'(q2), 64'h22);
    step(0, 0, 1, 18'h44, 0);
    check("g2_third", 64'(qg2), 64'h33);

    // Fill saturation with only bubbles.
    step(1, 0, 0, 18'h0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 18'(i), 0);
    check("d5_sat_fill", 64'(f5), 64'd5);
    check("d5_sat_vld", 64'(v5), 64'd0);

    // rst and flush together behave as rst.
    step(1, 1, 1, 18'h1234, 1);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 3) != 0, 18'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
